// File: rtl/my_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_pkg
// Description : Shared types and constants for the memory arbiter
//               (bus width, ROM/RAM split, FSM states, port indices).
// Revision    : 1.0  initial release
// ============================================================================
package my_pkg;

  localparam int DATA_WIDTH = 32;

  // Addresses below this value are ROM (read-only), the rest are RAM.
  localparam logic [DATA_WIDTH-1:0] ROM_LIMIT = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_port_t;

  // Unsigned full-width compare against the ROM/RAM boundary.
  function automatic logic is_rom(input logic [DATA_WIDTH-1:0] addr);
    return (addr < ROM_LIMIT);
  endfunction

endpackage : my_pkg
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner select between the fetch and data
//               requesters. Ties go to the pointer when ARB_ROUND_ROBIN_EN
//               is defined, otherwise the data port always wins.
// Revision    : 1.0  initial release
// ============================================================================
module arb_pick
  import my_pkg::*;
(
  input  logic      f_req_i,
  input  logic      d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_port_t ptr_i,
`endif
  output arb_port_t winner_o
);

  arb_port_t tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_winner = ptr_i;
`else
  assign tie_winner = DATA;
`endif

  // A lone requester wins outright; a tie falls to the tie-break choice.
  always_comb begin
    winner_o = FETCH;
    if (f_req_i && d_req_i) begin
      winner_o = tie_winner;
    end else if (d_req_i) begin
      winner_o = DATA;
    end
  end

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter/sequencer for the unified ROM/RAM memory.
//               Port 0 = instruction fetch (read only), port 1 = data
//               (read/write). IDLE -> ACCESS -> RESP sequencing, registered
//               read data, writes into the ROM region are rejected.
//               Optional macro: ARB_ROUND_ROBIN_EN (alternating tie-break).
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import my_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req_i,
  input  logic [DATA_WIDTH-1:0] f_addr_i,
  output logic                  f_ack_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_t            state_q, state_d;
  arb_port_t             gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  arb_port_t             winner;
  logic                  grant;
  logic                  rom_hit;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t ptr_q, ptr_d;
`endif

  arb_pick u_pick (
    .f_req_i  (f_req_i),
    .d_req_i  (d_req_i),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr_i    (ptr_q),
`endif
    .winner_o (winner)
  );

  assign grant   = (state_q == IDLE) && (f_req_i || d_req_i);
  assign rom_hit = is_rom(addr_q);

  // Next-state, grant latching and read-data capture.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          gnt_d   = winner;
          if (winner == DATA) begin
            addr_d  = d_addr_i;
            we_d    = d_we_i;
            wdata_d = d_wdata_i;
          end else begin
            addr_d  = f_addr_i;
            we_d    = 1'b0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d = (winner == FETCH) ? DATA : FETCH;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          rdata_d = mem_rdata_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= FETCH;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

  // Write strobe is masked by rst so a reset during ACCESS cannot commit.
  assign mem_we_o = (state_q == ACCESS) && we_q && !rom_hit && !rst;
  assign f_ack_o  = (state_q == RESP) && (gnt_q == FETCH);
  assign d_ack_o  = (state_q == RESP) && (gnt_q == DATA);
  assign d_err_o  = (state_q == RESP) && (gnt_q == DATA) && we_q && rom_hit;

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the unified ROM/RAM memory system. It shares the single memory port between an instruction-fetch requester (port 0, read-only) and a data requester (port 1, read/write). It runs a three-state access FSM, registers the read data, and blocks writes that target the ROM region. It sits between the core's fetch/load-store units and the memory system, and owns that system's address, write-data and write-enable inputs.

## Interface
- DATA_WIDTH, from my_pkg (32): address/data width of all buses.
- ROM_LIMIT, 32'h1000_0000: addresses below this are ROM (read-only); addresses at or above it are RAM.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock domain, synchronous, active-high.
- f_req_i  input  1  fetch request; held high until f_ack_o.
- f_addr_i  input  DATA_WIDTH  fetch address.
- f_ack_o  output  1  one-cycle fetch completion pulse.
- d_req_i  input  1  data request; held high until d_ack_o.
- d_we_i  input  1  data write (1) / read (0).
- d_addr_i  input  DATA_WIDTH  data address.
- d_wdata_i  input  DATA_WIDTH  data write value.
- d_ack_o  output  1  one-cycle data completion pulse.
- d_err_o  output  1  valid with d_ack_o; write to the ROM region was rejected.
- rdata_o  output  DATA_WIDTH  registered read data; valid while f_ack_o or d_ack_o is high.
- mem_addr_o  output  DATA_WIDTH  address to the memory system.
- mem_wdata_o  output  DATA_WIDTH  write data to the memory system.
- mem_we_o  output  1  write enable to the memory system.
- mem_rdata_i  input  DATA_WIDTH  combinational read data from the memory system.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when either request is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Grant latch: on the IDLE->ACCESS edge, latch the winner (gnt), its address, and for port 1 its we and wdata. Requester inputs are ignored outside IDLE.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: arbitration policy per Configuration.
- ACCESS drives mem_addr_o and mem_wdata_o from the latches.
- mem_we_o=1 only in ACCESS, only for a port-1 write with addr >= ROM_LIMIT. Fetch never writes.
- At the end of ACCESS, mem_rdata_i is captured into rdata_o for reads. For writes, rdata_o holds its previous value.
- RESP asserts exactly one of f_ack_o/d_ack_o for that cycle.
- d_err_o=1 in RESP iff the granted data access was a write with addr < ROM_LIMIT; no memory write occurs in that case.
- Outside ACCESS: mem_we_o=0, mem_addr_o/mem_wdata_o hold their last values.
- Address compare is unsigned, full DATA_WIDTH. 32'h0FFF_FFFF is ROM; 32'h1000_0000 is RAM.

## Timing
- Reset values: state=IDLE; f_ack_o, d_ack_o, d_err_o, mem_we_o = 0; rdata_o, mem_addr_o, mem_wdata_o = 0; arbitration pointer favours port 0.
- Request seen high during cycle n (IDLE) -> ACCESS in cycle n+1 -> ack in cycle n+2.
- Sustained throughput: one transaction per 3 cycles.
- Requester drops or changes req in the cycle after its ack. IDLE re-samples it then; no duplicate service.
- rst asserted in any state: next cycle is IDLE with all reset values.
  - An in-flight transaction is dropped without ack.
  - No mem_we_o pulse occurs in the cycle after the reset edge.
- A request deasserted before grant (protocol violation) is simply not served.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Tie-break alternates.
  - The pointer flips to the non-winner after every grant, including single-requester grants.
  - Reset pointer = port 0.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, port 1 (data) always wins ties.
  - Pointer logic absent.

## Structure
- my_pkg gains:
  - ROM_LIMIT constant.
  - arb_state_t enum (IDLE, ACCESS, RESP).
  - port index typedef arb_port_t (FETCH=0, DATA=1).
- One sub-module, arb_pick: combinational winner select from the two requests and the pointer. The pointer register stays in mem_arbiter.

## Test plan
- Single fetch: f_addr_i=32'h0000_0010, ROM word=32'hDEAD_BEEF -> f_ack_o 2 cycles after req, rdata_o=32'hDEAD_BEEF, mem_we_o never high.
- RAM write then read: d_we_i=1, addr 32'h1000_0004, wdata 32'h1234_5678 -> mem_we_o one cycle in ACCESS, d_ack_o, d_err_o=0. Read-back gives rdata_o=32'h1234_5678.
- ROM write rejection: d_we_i=1, addr 32'h0FFF_FFFC -> d_ack_o with d_err_o=1, mem_we_o stays 0.
- Contention: both requests held continuously for 4 transactions.
  - With ARB_ROUND_ROBIN_EN: grants F,D,F,D.
  - Without ARB_ROUND_ROBIN_EN: D,D,D,D.
- Reset in ACCESS during a RAM write: rst high -> next cycle IDLE, no ack, all outputs zero; the memory location is unchanged.
- Boundary addresses: read 32'h0FFF_FFFF routes as ROM; write 32'h1000_0000 succeeds with err=0.
